// File: rtl/user_io_pkg.sv
// Shared constants, FSM states and round-robin helper for the user-IO SPI master.
package user_io_pkg;

  localparam logic [7:0] CMD_BUT_SW = 8'h01;
  localparam logic [7:0] CMD_JOY0   = 8'h02;
  localparam logic [7:0] CMD_JOY1   = 8'h03;

  localparam logic [7:0] CORE_TYPE_UNKNOWN  = 8'h55;
  localparam logic [7:0] CORE_TYPE_DUMB     = 8'hA0;
  localparam logic [7:0] CORE_TYPE_MINIMIG  = 8'hA1;
  localparam logic [7:0] CORE_TYPE_PACE     = 8'hA2;
  localparam logic [7:0] CORE_TYPE_MIST     = 8'hA3;
  localparam logic [7:0] CORE_TYPE_8BIT     = 8'hA4;
  localparam logic [7:0] CORE_TYPE_MINIMIG2 = 8'hA5;
  localparam logic [7:0] CORE_TYPE_ARCHIE   = 8'hA6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_PRESEL,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // Command slots are indexed 0..2 for cmd 1..3.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // First dirty slot after the last-sent one, wrapping back to the last-sent slot.
  function automatic logic [1:0] rr_pick(input logic [2:0] dirty, input logic [1:0] last);
    logic [1:0] c0;
    logic [1:0] c1;
    c0 = rr_next(last);
    c1 = rr_next(c0);
    if (dirty[c0])      return c0;
    else if (dirty[c1]) return c1;
    else                return last;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period timer for SCK: one strobe every CLK_DIV cycles while enabled, split into
// rise/fall by the current SCK level. Cleared whenever disabled so each frame starts aligned.
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = en && (cnt == CW'(CLK_DIV - 1));
  assign rise = tick & ~level;
  assign fall = tick & level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (!en || tick)  cnt <= '0;
    else                   cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/user_io_master.sv
// SPI master sending 16-bit {cmd,data} frames for changed inputs; captures core type on MISO.
// Frame = 35 half-periods + GAP_CYCLES + 2 CLK. USER_IO_MASTER_REFRESH_EN adds a periodic resend.
module user_io_master
  import user_io_pkg::*;
#(
  parameter int CLK_DIV        = 4,
  parameter int GAP_CYCLES     = 8,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [5:0] JOY0,
  input  logic [5:0] JOY1,
  input  logic [1:0] BUTTONS,
  input  logic [1:0] SWITCHES,
  output logic       SPI_CLK,
  output logic       SPI_SS_IO,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO,
  output logic [7:0] CORE_TYPE,
  output logic       CORE_VALID,
  output logic       BUSY
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t        state, state_nx;
  logic          sck_nx, ss_nx, mosi_nx;
  logic          latch, shift_en;
  logic          sck_en, rise, fall;
  logic [3:0]    snap_bs;
  logic [5:0]    snap_j0, snap_j1;
  logic [2:0]    dirty, chg, clr;
  logic          refresh;
  logic [1:0]    last, pick;
  logic [15:0]   frame, frame_ld;
  logic [4:0]    rise_cnt;
  logic [6:0]    cap;
  logic [GW-1:0] gap_cnt;

  assign sck_en = (state == ST_FLUSH) || (state == ST_PRESEL) ||
                  (state == ST_SHIFT) || (state == ST_HOLD);
  assign BUSY   = (state != ST_IDLE);

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk   (CLK),
    .rst_n (RESET_N),
    .en    (sck_en),
    .level (SPI_CLK),
    .rise  (rise),
    .fall  (fall)
  );

  assign chg[0] = ({SWITCHES, BUTTONS} != snap_bs);
  assign chg[1] = (JOY0 != snap_j0);
  assign chg[2] = (JOY1 != snap_j1);
  assign pick   = rr_pick(dirty, last);
  assign clr    = latch ? (3'b001 << pick) : 3'b000;

`ifdef USER_IO_MASTER_REFRESH_EN
  localparam int RW = $clog2(REFRESH_CYCLES);
  logic [RW-1:0] ref_cnt;

  assign refresh = (ref_cnt == RW'(REFRESH_CYCLES - 1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)     ref_cnt <= '0;
    else if (refresh) ref_cnt <= '0;
    else              ref_cnt <= ref_cnt + RW'(1);
  end
`else
  // No resend timer in this build; the interval comparison is constant-false.
  assign refresh = (REFRESH_CYCLES < 0);
`endif

  always_comb begin
    frame_ld = {CMD_BUT_SW, 4'b0000, SWITCHES, BUTTONS};
    case (pick)
      2'd1:    frame_ld = {CMD_JOY0, 2'b00, JOY0};
      2'd2:    frame_ld = {CMD_JOY1, 2'b00, JOY1};
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    sck_nx   = SPI_CLK;
    ss_nx    = SPI_SS_IO;
    mosi_nx  = SPI_MOSI;
    latch    = 1'b0;
    shift_en = 1'b0;
    case (state)
      ST_IDLE: if (|dirty) begin
        state_nx = ST_FLUSH;
        sck_nx   = 1'b1;
        latch    = 1'b1;
      end
      ST_FLUSH: if (fall) begin
        state_nx = ST_PRESEL;
        ss_nx    = 1'b0;
        mosi_nx  = frame[15];
      end
      ST_PRESEL: if (fall) begin
        state_nx = ST_SHIFT;
        sck_nx   = 1'b0;
      end
      ST_SHIFT: begin
        if (rise) sck_nx = 1'b1;
        if (fall) begin
          sck_nx   = 1'b0;
          mosi_nx  = frame[14];
          shift_en = 1'b1;
          if (rise_cnt == 5'd16) state_nx = ST_HOLD;
        end
      end
      ST_HOLD: if (rise) begin
        state_nx = ST_GAP;
        ss_nx    = 1'b1;
      end
      ST_GAP: if (gap_cnt == GW'(GAP_CYCLES)) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      SPI_CLK   <= 1'b0;
      SPI_SS_IO <= 1'b1;
      SPI_MOSI  <= 1'b0;
    end else begin
      state     <= state_nx;
      SPI_CLK   <= sck_nx;
      SPI_SS_IO <= ss_nx;
      SPI_MOSI  <= mosi_nx;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      snap_bs    <= '0;
      snap_j0    <= '0;
      snap_j1    <= '0;
      dirty      <= 3'b111;
      last       <= 2'd2;
      frame      <= '0;
      rise_cnt   <= '0;
      cap        <= '0;
      gap_cnt    <= '0;
      CORE_TYPE  <= 8'h00;
      CORE_VALID <= 1'b0;
    end else begin
      snap_bs <= {SWITCHES, BUTTONS};
      snap_j0 <= JOY0;
      snap_j1 <= JOY1;
      // A change in the latch cycle re-arms the flag being cleared.
      dirty   <= (dirty & ~clr) | chg | {3{refresh}};
      if (latch) begin
        frame    <= frame_ld;
        last     <= pick;
        rise_cnt <= '0;
      end else if (shift_en) begin
        frame <= {frame[14:0], 1'b0};
      end
      if (state == ST_SHIFT && rise) begin
        rise_cnt <= rise_cnt + 5'd1;
        if (rise_cnt < 5'd8) cap <= {cap[5:0], SPI_MISO};
        if (rise_cnt == 5'd7) begin
          CORE_TYPE  <= {cap, SPI_MISO};
          CORE_VALID <= 1'b1;
        end
      end
      gap_cnt <= (state == ST_GAP) ? gap_cnt + GW'(1) : '0;
    end
  end

endmodule

// File: tb/tb_user_io_master.sv
// Directed bench: bit-counting SPI slave model plus SS/SCK timing monitors around user_io_master.
module tb_user_io_master;

  localparam int  CLK_DIV        = 2;
  localparam int  GAP_CYCLES     = 2;
  localparam int  REFRESH_CYCLES = 500;
  localparam time HALF           = CLK_DIV * 10;
  localparam time PERIOD         = (35 * CLK_DIV + GAP_CYCLES + 2) * 10;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b1;
  logic [5:0] JOY0 = '0;
  logic [5:0] JOY1 = '0;
  logic [1:0] BUTTONS = '0;
  logic [1:0] SWITCHES = '0;
  logic       SPI_MISO = 1'b0;
  logic       SPI_CLK, SPI_SS_IO, SPI_MOSI, CORE_VALID, BUSY;
  logic [7:0] CORE_TYPE;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  user_io_master #(
    .CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES), .REFRESH_CYCLES(REFRESH_CYCLES)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .JOY0(JOY0), .JOY1(JOY1),
    .BUTTONS(BUTTONS), .SWITCHES(SWITCHES), .SPI_CLK(SPI_CLK),
    .SPI_SS_IO(SPI_SS_IO), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO),
    .CORE_TYPE(CORE_TYPE), .CORE_VALID(CORE_VALID), .BUSY(BUSY)
  );

  // Slave: bit counter only cleared by an SCK rise while SS is high.
  int          bitcnt = 0;
  logic [15:0] rx = '0;
  logic [15:0] frames[$];
  logic [7:0]  slave_type = 8'hA2;
  bit          rec_first = 1'b0;
  logic        obs_v7 = 1'b1;
  logic        obs_v9 = 1'b0;
  logic [7:0]  obs_t9 = 8'h00;

  always @(posedge SPI_CLK) begin
    if (SPI_SS_IO) bitcnt = 0;
    else begin
      rx = {rx[14:0], SPI_MOSI};
      bitcnt++;
      if (rec_first && bitcnt == 7) obs_v7 = CORE_VALID;
      if (rec_first && bitcnt == 9) begin
        obs_v9 = CORE_VALID;
        obs_t9 = CORE_TYPE;
        rec_first = 1'b0;
      end
      if (bitcnt == 16) begin
        frames.push_back(rx);
        bitcnt = 0;
      end
    end
  end

  always @(negedge SPI_CLK)
    if (!SPI_SS_IO) SPI_MISO = (bitcnt < 8) ? slave_type[3'(7 - bitcnt)] : 1'b0;

  time t_rise = 0, t_fall = 0, t_ssf = 0;
  bit  after_ssf = 1'b0, mon_en = 1'b0;
  time min_setup = 64'd1000000, min_hold = 64'd1000000, pre_min = 64'd1000000, pre_max = 0;
  time ss_falls[$];

  always @(posedge SPI_CLK) t_rise = $time;

  always @(negedge SPI_CLK) begin
    if (after_ssf) begin
      if (!SPI_SS_IO) begin
        if ($time - t_ssf < pre_min) pre_min = $time - t_ssf;
        if ($time - t_ssf > pre_max) pre_max = $time - t_ssf;
      end
      after_ssf = 1'b0;
    end
    t_fall = $time;
  end

  always @(negedge SPI_SS_IO) if (mon_en && RESET_N) begin
    t_ssf = $time;
    after_ssf = 1'b1;
    if ($time - t_rise < min_setup) min_setup = $time - t_rise;
    ss_falls.push_back($time);
  end

  always @(posedge SPI_SS_IO) if (mon_en && RESET_N)
    if ($time - t_fall < min_hold) min_hold = $time - t_fall;

  task automatic wait_frames(input int n, input int budget, input string name);
    int k = 0;
    while (frames.size() < n && k < budget) begin @(negedge CLK); k++; end
    total++;
    if (frames.size() < n) begin
      bad++;
      $display("FAIL %s_timeout frames=%0d required=%0d", name, frames.size(), n);
    end
  endtask

  task automatic wait_idle();
    int quiet = 0;
    int k = 0;
    while (quiet < 20 && k < 2000) begin
      @(negedge CLK);
      k++;
      quiet = BUSY ? 0 : quiet + 1;
    end
  endtask

  function automatic logic [15:0] frame_at(input int i);
    return (frames.size() > i) ? frames[i] : 16'hDEAD;
  endfunction

  task automatic test_reset();
    JOY0 = 6'h15; JOY1 = 6'h00; BUTTONS = 2'b00; SWITCHES = 2'b00; slave_type = 8'hA2;
    #2 RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    total++; if (SPI_CLK !== 1'b0)    begin bad++; $display("FAIL rst_sck got=%b req=0", SPI_CLK); end
    total++; if (SPI_SS_IO !== 1'b1)  begin bad++; $display("FAIL rst_ss got=%b req=1", SPI_SS_IO); end
    total++; if (SPI_MOSI !== 1'b0)   begin bad++; $display("FAIL rst_mosi got=%b req=0", SPI_MOSI); end
    total++; if (CORE_TYPE !== 8'h00) begin bad++; $display("FAIL rst_type got=%h req=00", CORE_TYPE); end
    total++; if (CORE_VALID !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b req=0", CORE_VALID); end
    total++; if (BUSY !== 1'b0)       begin bad++; $display("FAIL rst_busy got=%b req=0", BUSY); end
    frames.delete(); ss_falls.delete();
    rec_first = 1'b1; mon_en = 1'b1;
    @(posedge CLK); #1 RESET_N = 1'b1;
    wait_frames(3, 600, "reset");
    total++; if (frame_at(0) !== 16'h0100) begin bad++; $display("FAIL rst_f0 got=%h req=0100", frame_at(0)); end
    total++; if (frame_at(1) !== 16'h0215) begin bad++; $display("FAIL rst_f1 got=%h req=0215", frame_at(1)); end
    total++; if (frame_at(2) !== 16'h0300) begin bad++; $display("FAIL rst_f2 got=%h req=0300", frame_at(2)); end
    total++; if (obs_v7 !== 1'b0)   begin bad++; $display("FAIL valid_at_rise7 got=%b req=0", obs_v7); end
    total++; if (obs_v9 !== 1'b1)   begin bad++; $display("FAIL valid_at_rise9 got=%b req=1", obs_v9); end
    total++; if (obs_t9 !== 8'hA2)  begin bad++; $display("FAIL type_at_rise9 got=%h req=a2", obs_t9); end
    if (ss_falls.size() < 3) begin
      total++; bad++; $display("FAIL frame_period ss_falls=%0d req=3", ss_falls.size());
    end else begin
      total++; if (ss_falls[1] - ss_falls[0] !== PERIOD) begin bad++; $display("FAIL period01 got=%0d req=%0d", ss_falls[1] - ss_falls[0], PERIOD); end
      total++; if (ss_falls[2] - ss_falls[1] !== PERIOD) begin bad++; $display("FAIL period12 got=%0d req=%0d", ss_falls[2] - ss_falls[1], PERIOD); end
    end
  endtask

  task automatic test_idle_change();
    int lat = 0;
    wait_idle();
    frames.delete();
    @(posedge CLK); #1 JOY1 = 6'h3F;
    @(negedge CLK);
    while (!BUSY && lat < 50) begin @(posedge CLK); lat++; @(negedge CLK); end
    total++; if (lat !== 2) begin bad++; $display("FAIL idle_latency got=%0d req=2", lat); end
    wait_frames(1, 400, "idle");
    total++; if (frame_at(0) !== 16'h033F) begin bad++; $display("FAIL idle_f0 got=%h req=033f", frame_at(0)); end
    repeat (300) @(negedge CLK);
    total++; if (frames.size() !== 1) begin bad++; $display("FAIL idle_count got=%0d req=1", frames.size()); end
  endtask

  task automatic test_mid_frame_change();
    int k = 0;
    wait_idle();
    frames.delete();
    @(posedge CLK); #1 JOY0 = 6'h2A;
    while (SPI_SS_IO && k < 400) begin @(negedge CLK); k++; end
    repeat (10) @(negedge CLK);
    @(posedge CLK); #1 BUTTONS = 2'b10; SWITCHES = 2'b01;
    wait_frames(2, 600, "midchg");
    total++; if (frame_at(0) !== 16'h022A) begin bad++; $display("FAIL midchg_f0 got=%h req=022a", frame_at(0)); end
    total++; if (frame_at(1) !== 16'h0106) begin bad++; $display("FAIL midchg_f1 got=%h req=0106", frame_at(1)); end
    repeat (300) @(negedge CLK);
    total++; if (frames.size() !== 2) begin bad++; $display("FAIL midchg_count got=%0d req=2", frames.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int k = 0;
    wait_idle();
    slave_type = 8'hA5;
    frames.delete();
    @(posedge CLK); #1 JOY1 = 6'h11;
    while (bitcnt != 9 && k < 400) begin @(negedge CLK); k++; end
    total++; if (bitcnt != 9) begin bad++; $display("FAIL midrst_reach_bit9 got=%0d req=9", bitcnt); end
    @(negedge CLK); RESET_N = 1'b0;
    #1;
    total++; if (SPI_SS_IO !== 1'b1)  begin bad++; $display("FAIL midrst_ss got=%b req=1", SPI_SS_IO); end
    total++; if (SPI_CLK !== 1'b0)    begin bad++; $display("FAIL midrst_sck got=%b req=0", SPI_CLK); end
    total++; if (SPI_MOSI !== 1'b0)   begin bad++; $display("FAIL midrst_mosi got=%b req=0", SPI_MOSI); end
    total++; if (BUSY !== 1'b0)       begin bad++; $display("FAIL midrst_busy got=%b req=0", BUSY); end
    total++; if (CORE_TYPE !== 8'h00) begin bad++; $display("FAIL midrst_type got=%h req=00", CORE_TYPE); end
    total++; if (frames.size() !== 0) begin bad++; $display("FAIL midrst_partial got=%0d req=0", frames.size()); end
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;
    wait_frames(3, 600, "midrst");
    total++; if (frame_at(0) !== 16'h0106) begin bad++; $display("FAIL midrst_f0 got=%h req=0106", frame_at(0)); end
    total++; if (frame_at(1) !== 16'h022A) begin bad++; $display("FAIL midrst_f1 got=%h req=022a", frame_at(1)); end
    total++; if (frame_at(2) !== 16'h0311) begin bad++; $display("FAIL midrst_f2 got=%h req=0311", frame_at(2)); end
    @(negedge CLK);
    total++; if (CORE_TYPE !== 8'hA5) begin bad++; $display("FAIL midrst_coretype got=%h req=a5", CORE_TYPE); end
    total++; if (CORE_VALID !== 1'b1) begin bad++; $display("FAIL midrst_valid got=%b req=1", CORE_VALID); end
  endtask

  task automatic test_ss_timing();
    total++; if (pre_min !== HALF) begin bad++; $display("FAIL ss_to_presel_min got=%0d req=%0d", pre_min, HALF); end
    total++; if (pre_max !== HALF) begin bad++; $display("FAIL ss_to_presel_max got=%0d req=%0d", pre_max, HALF); end
    total++; if (min_setup < HALF) begin bad++; $display("FAIL ss_setup got=%0d req>=%0d", min_setup, HALF); end
    total++; if (min_hold < HALF)  begin bad++; $display("FAIL ss_hold got=%0d req>=%0d", min_hold, HALF); end
  endtask

  task automatic test_refresh();
    wait_idle();
    frames.delete();
`ifdef USER_IO_MASTER_REFRESH_EN
    repeat (1600) @(negedge CLK);
    total++; if (frames.size() < 6) begin bad++; $display("FAIL refresh_count got=%0d req>=6", frames.size()); end
    total++; if (frame_at(0) !== 16'h0106) begin bad++; $display("FAIL refresh_f0 got=%h req=0106", frame_at(0)); end
    total++; if (frame_at(1) !== 16'h022A) begin bad++; $display("FAIL refresh_f1 got=%h req=022a", frame_at(1)); end
    total++; if (frame_at(2) !== 16'h0311) begin bad++; $display("FAIL refresh_f2 got=%h req=0311", frame_at(2)); end
`else
    repeat (1200) @(negedge CLK);
    total++; if (frames.size() !== 0) begin bad++; $display("FAIL no_refresh_count got=%0d req=0", frames.size()); end
`endif
  endtask

  initial begin
    test_reset();
    test_idle_change();
    test_mid_frame_change();
    test_reset_mid_frame();
    test_ss_timing();
    test_refresh();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
